// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: issue/writeback handshake and scoreboard status bundle
interface reg_scoreboard_if;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs_a;
  logic [4:0]  rs_b;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        stall;
  logic [31:0] wb_we;
  logic [31:0] pending;
  logic [5:0]  pending_count;
  logic        wb_err;
  modport master (
    output issue_valid, issue_rd, rs_a, rs_b, wb_valid, wb_rd,
    input  stall, wb_we, pending, pending_count, wb_err
  );
  modport slave (
    input  issue_valid, issue_rd, rs_a, rs_b, wb_valid, wb_rd,
    output stall, wb_we, pending, pending_count, wb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: destination-register pending tracker with RAW/WAW stall and one-hot writeback enable
module reg_scoreboard #(
  parameter bit BYPASS = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  reg_scoreboard_if.slave sb
);
  logic [31:0] wb_hit;
  logic [31:0] eff;
  logic [31:0] set_vec;
  logic [31:0] pend_nxt;
  logic [5:0]  cnt_nxt;
  logic        accepted;
  logic        err_hit;
  always_comb begin
    wb_hit    = sb.wb_valid ? (32'd1 << sb.wb_rd) : '0;
    wb_hit[0] = 1'b0;
    // a same-cycle writeback hides its register from the hazard check only when forwarding exists
    eff       = sb.pending & ~(BYPASS ? wb_hit : 32'd0);
    sb.stall  = sb.issue_valid & (eff[sb.rs_a] | eff[sb.rs_b] | eff[sb.issue_rd]);
    accepted  = sb.issue_valid & ~sb.stall;
    set_vec   = accepted ? (32'd1 << sb.issue_rd) : '0;
    set_vec[0] = 1'b0;
    pend_nxt  = set_vec | (sb.pending & ~wb_hit);
    err_hit   = sb.wb_valid & (sb.wb_rd != 5'd0) & ~sb.pending[sb.wb_rd];
    cnt_nxt   = '0;
    for (int i = 1; i < 32; i++) cnt_nxt = cnt_nxt + {5'd0, pend_nxt[i]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.pending       <= '0;
      sb.pending_count <= '0;
      sb.wb_we         <= '0;
      sb.wb_err        <= 1'b0;
    end else begin
      sb.pending       <= pend_nxt;
      sb.pending_count <= cnt_nxt;
      sb.wb_we         <= wb_hit;
      sb.wb_err        <= sb.wb_err | err_hit;
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed checks of the scoreboard with and without same-cycle bypass
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  reg_scoreboard_if b1 ();
  reg_scoreboard_if b0 ();
  reg_scoreboard #(.BYPASS(1'b1)) u_byp (.clk(clk), .rst_n(rst_n), .sb(b1));
  reg_scoreboard #(.BYPASS(1'b0)) u_nob (.clk(clk), .rst_n(rst_n), .sb(b0));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic set1(input logic iv, input logic [4:0] ird, ra, rb, input logic wv, input logic [4:0] wr);
    b1.issue_valid = iv; b1.issue_rd = ird; b1.rs_a = ra; b1.rs_b = rb;
    b1.wb_valid = wv; b1.wb_rd = wr;
  endtask
  task automatic set0(input logic iv, input logic [4:0] ird, ra, rb, input logic wv, input logic [4:0] wr);
    b0.issue_valid = iv; b0.issue_rd = ird; b0.rs_a = ra; b0.rs_b = rb;
    b0.wb_valid = wv; b0.wb_rd = wr;
  endtask
  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask
  initial begin
    set1(0, 0, 0, 0, 0, 0);
    set0(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_pending", b1.pending, 32'h0);
    chk("rst_count", {26'd0, b1.pending_count}, 32'd0);
    chk("rst_wb_we", b1.wb_we, 32'h0);
    chk("rst_wb_err", {31'd0, b1.wb_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    // first issue, no hazard
    @(negedge clk); set1(1, 5, 1, 2, 0, 0); #1;
    chk("issue5_stall", {31'd0, b1.stall}, 32'd0);
    edge_sample();
    chk("issue5_pending", b1.pending, 32'h0000_0020);
    chk("issue5_count", {26'd0, b1.pending_count}, 32'd1);
    // RAW on r5, then bypassed by same-cycle writeback
    @(negedge clk); set1(1, 7, 5, 0, 0, 0); #1;
    chk("raw5_stall", {31'd0, b1.stall}, 32'd1);
    set1(1, 7, 5, 0, 1, 5); #1;
    chk("raw5_byp_stall", {31'd0, b1.stall}, 32'd0);
    edge_sample();
    chk("byp_wb_we", b1.wb_we, 32'h0000_0020);
    chk("byp_pending", b1.pending, 32'h0000_0080);
    chk("byp_count", {26'd0, b1.pending_count}, 32'd1);
    // issue and writeback of the same register: set wins
    @(negedge clk); set1(1, 7, 0, 0, 1, 7); #1;
    chk("waw7_byp_stall", {31'd0, b1.stall}, 32'd0);
    edge_sample();
    chk("setwins_pending", b1.pending, 32'h0000_0080);
    chk("setwins_wb_we", b1.wb_we, 32'h0000_0080);
    chk("setwins_count", {26'd0, b1.pending_count}, 32'd1);
    // register 0 is inert
    @(negedge clk); set1(1, 0, 0, 0, 0, 0); #1;
    chk("rd0_stall", {31'd0, b1.stall}, 32'd0);
    edge_sample();
    chk("rd0_pending", b1.pending, 32'h0000_0080);
    @(negedge clk); set1(0, 0, 0, 0, 1, 0);
    edge_sample();
    chk("wb0_wb_we", b1.wb_we, 32'h0);
    chk("wb0_wb_err", {31'd0, b1.wb_err}, 32'd0);
    chk("wb0_pending", b1.pending, 32'h0000_0080);
    // spurious writeback sets sticky error
    @(negedge clk); set1(0, 0, 0, 0, 1, 9);
    edge_sample();
    chk("err9_wb_err", {31'd0, b1.wb_err}, 32'd1);
    chk("err9_wb_we", b1.wb_we, 32'h0000_0200);
    chk("err9_pending", b1.pending, 32'h0000_0080);
    @(negedge clk); set1(0, 0, 0, 0, 1, 7);
    edge_sample();
    chk("err_hold1", {31'd0, b1.wb_err}, 32'd1);
    chk("wb7_pending", b1.pending, 32'h0);
    chk("wb7_count", {26'd0, b1.pending_count}, 32'd0);
    @(negedge clk); set1(0, 0, 0, 0, 0, 0);
    edge_sample();
    chk("idle_wb_we", b1.wb_we, 32'h0);
    chk("err_hold2", {31'd0, b1.wb_err}, 32'd1);
    // fill r1..r31
    for (int r = 1; r < 32; r++) begin
      @(negedge clk); set1(1, 5'(r), 0, 0, 0, 0);
      edge_sample();
    end
    chk("full_pending", b1.pending, 32'hFFFF_FFFE);
    chk("full_count", {26'd0, b1.pending_count}, 32'd31);
    @(negedge clk); set1(1, 3, 0, 0, 0, 0); #1;
    chk("full_waw_stall", {31'd0, b1.stall}, 32'd1);
    set1(0, 0, 0, 0, 1, 31);
    edge_sample();
    chk("wb31_pending", b1.pending, 32'h7FFF_FFFE);
    chk("wb31_count", {26'd0, b1.pending_count}, 32'd30);
    chk("wb31_wb_we", b1.wb_we, 32'h8000_0000);
    // async reset between edges
    @(negedge clk); set1(0, 0, 0, 0, 0, 0); #1;
    rst_n = 1'b0; #1;
    chk("arst_pending", b1.pending, 32'h0);
    chk("arst_count", {26'd0, b1.pending_count}, 32'd0);
    chk("arst_wb_we", b1.wb_we, 32'h0);
    chk("arst_wb_err", {31'd0, b1.wb_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); set1(1, 3, 0, 0, 0, 0);
    edge_sample();
    chk("post_rst_pending", b1.pending, 32'h0000_0008);
    chk("post_rst_count", {26'd0, b1.pending_count}, 32'd1);
    @(negedge clk); set1(0, 0, 0, 0, 0, 0);
    // no-bypass instance: dependent issue waits one extra cycle
    @(negedge clk); set0(1, 5, 1, 2, 0, 0);
    edge_sample();
    chk("nb_pending5", b0.pending, 32'h0000_0020);
    @(negedge clk); set0(0, 7, 5, 5, 0, 0); #1;
    chk("nb_novalid_stall", {31'd0, b0.stall}, 32'd0);
    set0(1, 7, 5, 0, 1, 5); #1;
    chk("nb_wb_stall", {31'd0, b0.stall}, 32'd1);
    edge_sample();
    chk("nb_wb_pending", b0.pending, 32'h0);
    chk("nb_wb_we", b0.wb_we, 32'h0000_0020);
    @(negedge clk); set0(1, 7, 5, 0, 0, 0); #1;
    chk("nb_late_stall", {31'd0, b0.stall}, 32'd0);
    edge_sample();
    chk("nb_late_pending", b0.pending, 32'h0000_0080);
    chk("nb_late_count", {26'd0, b0.pending_count}, 32'd1);
    chk("nb_late_wb_we", b0.wb_we, 32'h0);
    @(negedge clk); set0(0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
